// File: rtl/rgb_led_sequencer.sv
// RGB LED sequencer: steps through a 4-entry colour/duration table and drives the pins with per-channel PWM.
// Define LED_SEQ_OVERRIDE_EN to build the one-shot override colour path (ovr_* handshake and OVR state).
module rgb_led_sequencer #(
  parameter int PWM_BITS = 8,
  parameter int TICK_DIV = 24000,
  parameter int DUR_BITS = 16
) (
  input  logic                           clk24,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           cfg_we,
  input  logic [1:0]                     cfg_addr,
  input  logic [3*PWM_BITS+DUR_BITS-1:0] cfg_data,
  input  logic                           ovr_valid,
  output logic                           ovr_ready,
  input  logic [3*PWM_BITS-1:0]          ovr_rgb,
  input  logic [DUR_BITS-1:0]            ovr_dur,
  output logic                           led_r,
  output logic                           led_g,
  output logic                           led_b,
  output logic [1:0]                     step_idx,
  output logic                           ovr_active
);

  function automatic logic [DUR_BITS-1:0] dur_sat(input longint ticks);
    if (ticks > ((longint'(1) << DUR_BITS) - 1)) return '1;
    return DUR_BITS'(ticks);
  endfunction

  function automatic logic [DUR_BITS-1:0] dur_min1(input logic [DUR_BITS-1:0] d);
    return (d == '0) ? DUR_BITS'(1) : d;
  endfunction

  localparam int                  PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;
  localparam logic [DUR_BITS-1:0] RST_DUR    = dur_sat(500);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
`ifdef LED_SEQ_OVERRIDE_EN
  localparam logic [1:0] S_OVR  = 2'd2;
`endif

  logic [PWM_BITS-1:0] tab_r [4];
  logic [PWM_BITS-1:0] tab_g [4];
  logic [PWM_BITS-1:0] tab_b [4];
  logic [DUR_BITS-1:0] tab_dur [4];

  logic [1:0]          state, state_nx, idx_nx;
  logic                load_step, load_ovr, ovr_acc, expire;
  logic [PRESC_W-1:0]  presc;
  logic [DUR_BITS-1:0] tick_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] cur_r, cur_g, cur_b;
  logic [DUR_BITS-1:0] cur_dur;
  logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        tab_r[i]   <= (i == 0) ? DUTY_MAX : '0;
        tab_g[i]   <= (i == 1) ? DUTY_MAX : '0;
        tab_b[i]   <= (i == 2) ? DUTY_MAX : '0;
        tab_dur[i] <= RST_DUR;
      end
    end else if (cfg_we) begin
      tab_r[cfg_addr]   <= cfg_data[3*PWM_BITS+DUR_BITS-1 -: PWM_BITS];
      tab_g[cfg_addr]   <= cfg_data[2*PWM_BITS+DUR_BITS-1 -: PWM_BITS];
      tab_b[cfg_addr]   <= cfg_data[PWM_BITS+DUR_BITS-1 -: PWM_BITS];
      tab_dur[cfg_addr] <= cfg_data[DUR_BITS-1:0];
    end
  end

`ifdef LED_SEQ_OVERRIDE_EN
  assign ovr_acc    = ovr_valid & ovr_ready;
  assign ovr_active = (state == S_OVR);
`else
  logic unused_ovr;
  assign unused_ovr = ^{ovr_valid, ovr_rgb, ovr_dur};
  assign ovr_acc    = 1'b0;
  assign ovr_active = 1'b0;
  assign ovr_ready  = 1'b0;
`endif

  // cur_dur is already forced >= 1, so the last tick is cur_dur-1
  assign expire = (state != S_IDLE) && (presc == PRESC_LAST) &&
                  (tick_cnt == cur_dur - DUR_BITS'(1));

  always_comb begin
    state_nx  = state;
    idx_nx    = step_idx;
    load_step = 1'b0;
    load_ovr  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ovr_acc) begin
          state_nx = S_OVR_OR_IDLE();
          load_ovr = 1'b1;
        end else if (enable) begin
          state_nx  = S_RUN;
          idx_nx    = 2'd0;
          load_step = 1'b1;
        end
      end
      S_RUN: begin
        if (ovr_acc) begin
          state_nx = S_OVR_OR_IDLE();
          load_ovr = 1'b1;
        end else if (!enable) begin
          state_nx = S_IDLE;
          idx_nx   = 2'd0;
        end else if (expire) begin
          idx_nx    = step_idx + 2'd1;
          load_step = 1'b1;
        end
      end
`ifdef LED_SEQ_OVERRIDE_EN
      S_OVR: begin
        if (expire) begin
          state_nx  = enable ? S_RUN : S_IDLE;
          idx_nx    = 2'd0;
          load_step = enable;
        end
      end
`endif
      default: begin
        state_nx = S_IDLE;
        idx_nx   = 2'd0;
      end
    endcase
  end

  function automatic logic [1:0] S_OVR_OR_IDLE();
`ifdef LED_SEQ_OVERRIDE_EN
    return S_OVR;
`else
    return S_IDLE;
`endif
  endfunction

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      step_idx <= 2'd0;
      presc    <= '0;
      tick_cnt <= '0;
      pwm_cnt  <= '0;
    end else begin
      state    <= state_nx;
      step_idx <= idx_nx;
      pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
      if (load_step || load_ovr || (state_nx == S_IDLE)) begin
        presc    <= '0;
        tick_cnt <= '0;
      end else if (presc == PRESC_LAST) begin
        presc    <= '0;
        tick_cnt <= tick_cnt + DUR_BITS'(1);
      end else begin
        presc    <= presc + PRESC_W'(1);
      end
    end
  end

`ifdef LED_SEQ_OVERRIDE_EN
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) ovr_ready <= 1'b0;
    else        ovr_ready <= (state_nx != S_OVR);
  end
`endif

  // Stage: colour/duration latched on step or override entry
  always_ff @(posedge clk24) begin
    if (load_step) begin
      cur_r   <= tab_r[idx_nx];
      cur_g   <= tab_g[idx_nx];
      cur_b   <= tab_b[idx_nx];
      cur_dur <= dur_min1(tab_dur[idx_nx]);
    end else if (load_ovr) begin
      cur_r   <= ovr_rgb[3*PWM_BITS-1 -: PWM_BITS];
      cur_g   <= ovr_rgb[2*PWM_BITS-1 -: PWM_BITS];
      cur_b   <= ovr_rgb[PWM_BITS-1:0];
      cur_dur <= dur_min1(ovr_dur);
    end
  end

  assign duty_r = (state == S_IDLE) ? '0 : cur_r;
  assign duty_g = (state == S_IDLE) ? '0 : cur_g;
  assign duty_b = (state == S_IDLE) ? '0 : cur_b;

  // Stage: duty compare registered onto the pins
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      led_r <= 1'b0;
      led_g <= 1'b0;
      led_b <= 1'b0;
    end else begin
      led_r <= (pwm_cnt < duty_r);
      led_g <= (pwm_cnt < duty_g);
      led_b <= (pwm_cnt < duty_b);
    end
  end

endmodule
